// File: rtl/conv_16_18_acc_sat.sv
// -----------------------------------------------------------------------------
// conv_16_18_acc_sat
//
// Purpose:
//   Accumulates NUM_TAPS signed 24-bit products from an upstream 16x8
//   multiplier into a 32-bit signed sum. The sum is optionally rounded,
//   arithmetically shifted right by SHIFT and saturated to a signed 16-bit
//   result. That result is presented on a valid/ready output port.
//   The block has a two-state FSM:
//     ACC - accept products (prod_rdy=1).
//     OUT - present the result (out_vld=1) until downstream takes it.
//
// Configuration macro:
//   CONV_16_18_ACC_ROUND_EN
//     Defined   : adds 2^(SHIFT-1) before the shift (round half toward +inf).
//     Undefined : pure truncation toward -inf.
//
// Parameters:
//   ID       - instance identifier, no functional effect
//   NUM_TAPS - products accumulated per output (1..256)
//   SHIFT    - arithmetic right shift applied to the sum (0..15)
//
// Ports:
//   ap_clk    in   1   clock, rising edge
//   ap_rst    in   1   synchronous active-high reset
//   prod_V    in  24   signed product
//   prod_vld  in   1   prod_V valid
//   prod_rdy  out  1   block accepts prod_V (low during reset and in OUT)
//   out_V     out 16   signed rounded/saturated result
//   out_vld   out  1   out_V valid
//   out_rdy   in   1   downstream accepts out_V
//   ovf_flag  out  1   sticky saturation indicator, cleared only by reset
// -----------------------------------------------------------------------------
module conv_16_18_acc_sat #(
  parameter logic [31:0] ID       = 32'd1,
  parameter int          NUM_TAPS = 9,
  parameter int          SHIFT    = 7
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [23:0] prod_V,
  input  logic        prod_vld,
  output logic        prod_rdy,
  output logic [15:0] out_V,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic        ovf_flag
);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  // Rounding constant. (1 <<< SHIFT) >>> 1 yields 2^(SHIFT-1), and yields 0
  // when SHIFT is 0, so no negative shift amount is ever formed.
`ifdef CONV_16_18_ACC_ROUND_EN
  localparam logic signed [32:0] RND_ADD = (33'sd1 <<< SHIFT) >>> 1;
`else
  localparam logic signed [32:0] RND_ADD = 33'sd0;
`endif

  localparam logic [8:0] LAST_CNT = 9'(NUM_TAPS - 1);

  // Clamp a widened value into the signed 16-bit output range.
  function automatic logic [15:0] sat16(input logic signed [32:0] v);
    logic [15:0] r;
    if (v > 33'sd32767) begin
      r = 16'h7FFF;
    end else if (v < -33'sd32768) begin
      r = 16'h8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  // Report whether sat16 would clip the value.
  function automatic logic clips16(input logic signed [32:0] v);
    logic r;
    if ((v > 33'sd32767) || (v < -33'sd32768)) begin
      r = 1'b1;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic signed [31:0] r_acc;
  logic [8:0]         r_cnt;
  logic [15:0]        r_out;
  logic               r_ovf;

  logic signed [31:0] w_prod_ext;
  logic signed [31:0] w_sum;
  logic signed [32:0] w_rnd;
  logic signed [32:0] w_shf;
  logic               w_accept;
  logic               w_last;

  assign w_prod_ext = {{8{prod_V[23]}}, prod_V};
  assign w_sum      = r_acc + w_prod_ext;
  // One extra bit so that the rounding add cannot wrap at the top of range.
  assign w_rnd      = {w_sum[31], w_sum} + RND_ADD;
  assign w_shf      = w_rnd >>> SHIFT;
  assign w_accept   = prod_vld & prod_rdy;
  assign w_last     = w_accept & (r_cnt == LAST_CNT);

  assign out_V    = r_out;
  assign ovf_flag = r_ovf;

  // FSM state register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and handshake outputs; prod_rdy is masked by reset.
  always_comb begin
    w_state_nxt = r_state;
    prod_rdy    = 1'b0;
    out_vld     = 1'b0;
    case (r_state)
      ST_ACC: begin
        prod_rdy = ~ap_rst;
        if (w_last) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_state_nxt = ST_ACC;
        end
      end
      ST_OUT: begin
        out_vld = 1'b1;
        if (out_rdy) begin
          w_state_nxt = ST_ACC;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_ACC;
      end
    endcase
  end

  // Accumulator, tap counter, result register and sticky overflow flag.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_acc <= 32'sd0;
      r_cnt <= 9'd0;
      r_out <= 16'd0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 9'd1;
            if (w_last) begin
              r_out <= sat16(w_shf);
              r_ovf <= r_ovf | clips16(w_shf);
            end
          end
        end
        ST_OUT: begin
          // out_V keeps the delivered result; only the window state clears.
          if (out_rdy) begin
            r_acc <= 32'sd0;
            r_cnt <= 9'd0;
          end
        end
        default: begin
          r_acc <= 32'sd0;
          r_cnt <= 9'd0;
        end
      endcase
    end
  end

endmodule
